// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: produces next_pc each cycle, tracks the issued PC,
// handles stall/redirect/halt, and optionally boot-loads IMEM before running.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 16384,
  parameter int unsigned AW         = 14,
  parameter bit          BOOT_LOAD  = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          halt,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic [31:0]   next_pc,
  output logic          fetch_valid,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          running,
  output logic          err
);

  typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;

  localparam logic [AW-1:0] LastIdx   = AW'(IMEM_WORDS - 1);
  localparam logic [29:0]   WordLimit = 30'(IMEM_WORDS);

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          first_q, first_d;
  logic [AW-1:0] load_cnt_q, load_cnt_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic          err_q, err_d;
  logic          out_of_range;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT_LOAD ? StLoad : StRun;
      pc_q          <= RESET_PC;
      first_q       <= 1'b1;
      load_cnt_q    <= '0;
      fetch_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      first_q       <= first_d;
      load_cnt_q    <= load_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      err_q         <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    // An out-of-range target is never issued, so the PC register holds.
    pc_d          = out_of_range ? pc_q : next_pc;
    first_d       = first_q;
    load_cnt_d    = load_cnt_q;
    fetch_valid_d = 1'b0;
    err_d         = err_q;
    unique case (state_q)
      StLoad: begin
        if (load_valid) begin
          load_cnt_d = load_cnt_q + AW'(1);
          if (load_last) begin
            state_d = StRun;
            first_d = 1'b1;
          end else if (load_cnt_q == LastIdx) begin
            err_d   = 1'b1;
            state_d = StHalt;
          end
        end
      end
      StRun: begin
        first_d = 1'b0;
        if (halt) begin
          state_d = StHalt;
        end else if (out_of_range) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          fetch_valid_d = 1'b1;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase
  end

  // Outputs
  always_comb begin
    next_pc = pc_q;
    // halt outranks redirect and stall: the PC simply holds.
    if (state_q == StRun && !halt) begin
      if (first_q) begin
        next_pc = RESET_PC;
      end else if (redirect) begin
        next_pc = {redirect_pc[31:2], 2'b00};
      end else if (!stall) begin
        next_pc = pc_q + 32'd4;
      end
    end
    out_of_range = (state_q == StRun) && !halt && (next_pc[31:2] >= WordLimit);
    imem_we      = (state_q == StLoad) && load_valid && !reset;
    imem_waddr   = load_cnt_q;
    imem_wdata   = load_data;
    running      = (state_q == StRun);
  end

  assign fetch_valid = fetch_valid_q;
  assign err         = err_q;

endmodule
